// File: rtl/icache_miss_refill_pkg.sv
// Shared definitions for the instruction-cache miss/refill path: line geometry,
// derived widths and the refill FSM state encoding.
package icache_miss_refill_pkg;

  localparam int OFFSET_SIZE = 5;
  localparam int INDEX_SIZE  = 8;
  localparam int TAG_SIZE    = 64 - (OFFSET_SIZE + INDEX_SIZE);
  localparam int LINE_BYTES  = 2 ** OFFSET_SIZE;
  localparam int LINE_BITS   = LINE_BYTES * 8;
  localparam int BUS_WIDTH   = 64;
  localparam int NUM_BEATS   = LINE_BITS / BUS_WIDTH;
  localparam int CNT_W       = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_FILL   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_REPLAY = 3'd4
  } refill_state_e;

  function automatic logic [63:0] line_addr(input logic [TAG_SIZE-1:0]   tag,
                                            input logic [INDEX_SIZE-1:0] idx);
    return {tag, idx, {OFFSET_SIZE{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_miss_refill_line_fill_buffer.sv
// Beat counter and slot registers that assemble memory beats into one cacheline.
// line_next_o shows the line including a beat being stored this cycle.
module icache_miss_refill_line_fill_buffer
  import icache_miss_refill_pkg::*;
(
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic                 store_i,
  input  logic [BUS_WIDTH-1:0] data_i,
  output logic                 last_o,
  output logic [LINE_BITS-1:0] line_next_o
);

  logic [CNT_W-1:0]                    count_q, count_d;
  logic [NUM_BEATS-1:0][BUS_WIDTH-1:0] slots_q, slots_d;

  // Next-state for counter and slots; count wraps naturally after the last beat.
  always_comb begin
    count_d = count_q;
    slots_d = slots_q;
    last_o  = 1'b0;
    if (clear_i) begin
      count_d = '0;
    end else if (store_i) begin
      slots_d[count_q] = data_i;
      count_d          = count_q + CNT_W'(1);
      last_o           = (count_q == CNT_W'(NUM_BEATS - 1));
    end else begin
      count_d = count_q;
    end
  end

  assign line_next_o = slots_d;

  // Counter and slot storage.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
      slots_q <= '0;
    end else begin
      count_q <= count_d;
      slots_q <= slots_d;
    end
  end

endmodule

// File: rtl/icache_miss_refill.sv
// L1 instruction-cache miss handler: latches one miss, fetches the line from memory,
// writes it to the tag/data arrays and replays the fetch. All outputs are registered.
module icache_miss_refill
  import icache_miss_refill_pkg::*;
(
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  missValid_i,
  input  logic [TAG_SIZE-1:0]   missTag_i,
  input  logic [INDEX_SIZE-1:0] missIndex_i,
  input  logic [OFFSET_SIZE-1:0] missOffset_i,
  output logic                  busy_o,
  output logic                  memReqValid_o,
  output logic [63:0]           memReqAddr_o,
  input  logic                  memReqReady_i,
  input  logic                  memRespValid_i,
  input  logic [BUS_WIDTH-1:0]  memRespData_i,
  output logic                  lineWrEnable_o,
  output logic [INDEX_SIZE-1:0] lineWrIndex_o,
  output logic [TAG_SIZE:0]     lineWrTag_o,
  output logic [LINE_BITS-1:0]  lineWrData_o,
  output logic                  replayEnable_o,
  output logic [TAG_SIZE-1:0]   replayTag_o,
  output logic [INDEX_SIZE-1:0] replayIndex_o,
  output logic [OFFSET_SIZE-1:0] replayOffset_o
);

  refill_state_e          state_q, state_d;
  logic [TAG_SIZE-1:0]    tag_q, tag_d;
  logic [INDEX_SIZE-1:0]  index_q, index_d;
  logic [OFFSET_SIZE-1:0] offset_q, offset_d;
  logic                   busy_q, busy_d;
  logic                   req_valid_q, req_valid_d;
  logic [63:0]            req_addr_q, req_addr_d;
  logic                   wr_en_q, wr_en_d;
  logic [INDEX_SIZE-1:0]  wr_index_q, wr_index_d;
  logic [TAG_SIZE:0]      wr_tag_q, wr_tag_d;
  logic [LINE_BITS-1:0]   wr_data_q, wr_data_d;
  logic                   rp_en_q, rp_en_d;
  logic [TAG_SIZE-1:0]    rp_tag_q, rp_tag_d;
  logic [INDEX_SIZE-1:0]  rp_index_q, rp_index_d;
  logic [OFFSET_SIZE-1:0] rp_offset_q, rp_offset_d;

  logic                   fill_clear;
  logic                   fill_store;
  logic                   fill_last;
  logic [LINE_BITS-1:0]   fill_line;

  icache_miss_refill_line_fill_buffer u_fill (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .clear_i     (fill_clear),
    .store_i     (fill_store),
    .data_i      (memRespData_i),
    .last_o      (fill_last),
    .line_next_o (fill_line)
  );

  // Refill sequencing; outputs are computed one cycle ahead so they leave on flops.
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    index_d     = index_q;
    offset_d    = offset_q;
    busy_d      = busy_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    wr_en_d     = 1'b0;
    wr_index_d  = wr_index_q;
    wr_tag_d    = wr_tag_q;
    wr_data_d   = wr_data_q;
    rp_en_d     = 1'b0;
    rp_tag_d    = rp_tag_q;
    rp_index_d  = rp_index_q;
    rp_offset_d = rp_offset_q;
    fill_clear  = 1'b0;
    fill_store  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (missValid_i) begin
          tag_d       = missTag_i;
          index_d     = missIndex_i;
          offset_d    = missOffset_i;
          busy_d      = 1'b1;
          req_valid_d = 1'b1;
          req_addr_d  = line_addr(missTag_i, missIndex_i);
          state_d     = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (req_valid_q && memReqReady_i) begin
          req_valid_d = 1'b0;
          fill_clear  = 1'b1;
          state_d     = ST_FILL;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_FILL: begin
        if (memRespValid_i) begin
          fill_store = 1'b1;
          if (fill_last) begin
            wr_en_d    = 1'b1;
            wr_index_d = index_q;
            wr_tag_d   = {tag_q, 1'b1};
            wr_data_d  = fill_line;
            state_d    = ST_WRITE;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_WRITE: begin
        rp_en_d     = 1'b1;
        rp_tag_d    = tag_q;
        rp_index_d  = index_q;
        rp_offset_d = offset_q;
        state_d     = ST_REPLAY;
      end
      ST_REPLAY: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d      = 1'b0;
        req_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      tag_q       <= '0;
      index_q     <= '0;
      offset_q    <= '0;
      busy_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_index_q  <= '0;
      wr_tag_q    <= '0;
      wr_data_q   <= '0;
      rp_en_q     <= 1'b0;
      rp_tag_q    <= '0;
      rp_index_q  <= '0;
      rp_offset_q <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      index_q     <= index_d;
      offset_q    <= offset_d;
      busy_q      <= busy_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      wr_en_q     <= wr_en_d;
      wr_index_q  <= wr_index_d;
      wr_tag_q    <= wr_tag_d;
      wr_data_q   <= wr_data_d;
      rp_en_q     <= rp_en_d;
      rp_tag_q    <= rp_tag_d;
      rp_index_q  <= rp_index_d;
      rp_offset_q <= rp_offset_d;
    end
  end

  assign busy_o         = busy_q;
  assign memReqValid_o  = req_valid_q;
  assign memReqAddr_o   = req_addr_q;
  assign lineWrEnable_o = wr_en_q;
  assign lineWrIndex_o  = wr_index_q;
  assign lineWrTag_o    = wr_tag_q;
  assign lineWrData_o   = wr_data_q;
  assign replayEnable_o = rp_en_q;
  assign replayTag_o    = rp_tag_q;
  assign replayIndex_o  = rp_index_q;
  assign replayOffset_o = rp_offset_q;

endmodule

// File: tb/tb_icache_miss_refill.sv
// Directed self-checking bench for icache_miss_refill: basic refill, request backpressure,
// gapped beats, miss while busy, reset mid-fill and index/tag wrap.
module tb_icache_miss_refill;
  import icache_miss_refill_pkg::*;

  logic                   clock_i = 1'b0;
  logic                   reset_i = 1'b1;
  logic                   missValid_i = 1'b0;
  logic [TAG_SIZE-1:0]    missTag_i = '0;
  logic [INDEX_SIZE-1:0]  missIndex_i = '0;
  logic [OFFSET_SIZE-1:0] missOffset_i = '0;
  logic                   busy_o;
  logic                   memReqValid_o;
  logic [63:0]            memReqAddr_o;
  logic                   memReqReady_i = 1'b0;
  logic                   memRespValid_i = 1'b0;
  logic [BUS_WIDTH-1:0]   memRespData_i = '0;
  logic                   lineWrEnable_o;
  logic [INDEX_SIZE-1:0]  lineWrIndex_o;
  logic [TAG_SIZE:0]      lineWrTag_o;
  logic [LINE_BITS-1:0]   lineWrData_o;
  logic                   replayEnable_o;
  logic [TAG_SIZE-1:0]    replayTag_o;
  logic [INDEX_SIZE-1:0]  replayIndex_o;
  logic [OFFSET_SIZE-1:0] replayOffset_o;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int rp_cnt   = 0;
  int req_cnt  = 0;
  logic req_prev = 1'b0;

  icache_miss_refill dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .missValid_i    (missValid_i),
    .missTag_i      (missTag_i),
    .missIndex_i    (missIndex_i),
    .missOffset_i   (missOffset_i),
    .busy_o         (busy_o),
    .memReqValid_o  (memReqValid_o),
    .memReqAddr_o   (memReqAddr_o),
    .memReqReady_i  (memReqReady_i),
    .memRespValid_i (memRespValid_i),
    .memRespData_i  (memRespData_i),
    .lineWrEnable_o (lineWrEnable_o),
    .lineWrIndex_o  (lineWrIndex_o),
    .lineWrTag_o    (lineWrTag_o),
    .lineWrData_o   (lineWrData_o),
    .replayEnable_o (replayEnable_o),
    .replayTag_o    (replayTag_o),
    .replayIndex_o  (replayIndex_o),
    .replayOffset_o (replayOffset_o)
  );

  always #5 clock_i = ~clock_i;

  // Pulse and request-issue counters, sampled away from the active edge.
  always @(negedge clock_i) begin
    if (lineWrEnable_o) wr_cnt++;
    if (replayEnable_o) rp_cnt++;
    if (memReqValid_o && !req_prev) req_cnt++;
    req_prev = memReqValid_o;
  end

  logic [511:0] all_outs;
  assign all_outs = 512'({busy_o, memReqValid_o, memReqAddr_o, lineWrEnable_o, lineWrIndex_o,
                          lineWrTag_o, lineWrData_o, replayEnable_o, replayTag_o,
                          replayIndex_o, replayOffset_o});

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  function automatic logic [63:0] beat(input logic [7:0] seed, input int k);
    logic [7:0] b;
    b = seed * 8'(k + 1);
    return {8{b}};
  endfunction

  function automatic logic [LINE_BITS-1:0] exp_line(input logic [7:0] seed);
    logic [LINE_BITS-1:0] l;
    for (int k = 0; k < NUM_BEATS; k++) l[k*64 +: 64] = beat(seed, k);
    return l;
  endfunction

  // Present a miss for one cycle; afterwards the DUT is in REQ.
  task automatic present_miss(input logic [TAG_SIZE-1:0] t, input logic [INDEX_SIZE-1:0] i,
                              input logic [OFFSET_SIZE-1:0] o, input logic [63:0] exp_addr);
    missValid_i = 1'b1; missTag_i = t; missIndex_i = i; missOffset_i = o;
    step();
    missValid_i = 1'b0; missTag_i = '0; missIndex_i = '0; missOffset_i = '0;
    check("req_valid", 512'(memReqValid_o), 512'(1));
    check("req_addr", 512'(memReqAddr_o), 512'(exp_addr));
    check("busy_req", 512'(busy_o), 512'(1));
  endtask

  // Feed all beats starting in FILL, then check WRITE, REPLAY and the idle cycle after.
  task automatic finish_refill(input logic [7:0] seed, input int gap,
                               input logic [TAG_SIZE-1:0] t, input logic [INDEX_SIZE-1:0] i,
                               input logic [OFFSET_SIZE-1:0] o);
    int wr0;
    wr0 = wr_cnt;
    for (int k = 0; k < NUM_BEATS; k++) begin
      memRespValid_i = 1'b1; memRespData_i = beat(seed, k);
      step();
      memRespValid_i = 1'b0; memRespData_i = '0;
      if (k < NUM_BEATS - 1) repeat (gap) step();
    end
    check("wr_en", 512'(lineWrEnable_o), 512'(1));
    check("wr_index", 512'(lineWrIndex_o), 512'(i));
    check("wr_tag", 512'(lineWrTag_o), 512'({t, 1'b1}));
    check("wr_data", 512'(lineWrData_o), 512'(exp_line(seed)));
    step();
    check("wr_en_drop", 512'(lineWrEnable_o), 512'(0));
    check("rp_en", 512'(replayEnable_o), 512'(1));
    check("rp_fields", 512'({replayTag_o, replayIndex_o, replayOffset_o}), 512'({t, i, o}));
    check("busy_rp", 512'(busy_o), 512'(1));
    step();
    check("rp_drop", 512'(replayEnable_o), 512'(0));
    check("busy_idle", 512'(busy_o), 512'(0));
    check("rp_hold", 512'({replayTag_o, replayIndex_o, replayOffset_o}), 512'({t, i, o}));
    check("one_write", 512'(wr_cnt - wr0), 512'(1));
  endtask

  initial begin
    int wr0, rp0, req0;
    logic [63:0] addr0;

    // Reset state
    repeat (2) step();
    check("reset_zero", all_outs, 512'(0));
    reset_i = 1'b0;
    step();
    check("idle_zero", all_outs, 512'(0));

    // Basic refill with minimum latency
    memReqReady_i = 1'b1;
    present_miss(51'h1, 8'h02, 5'h0C, 64'h2040);
    step();
    check("req_drop", 512'(memReqValid_o), 512'(0));
    finish_refill(8'h11, 0, 51'h1, 8'h02, 5'h0C);

    // Ready backpressure
    memReqReady_i = 1'b0;
    req0 = req_cnt;
    present_miss(51'h2, 8'h03, 5'h01, 64'h4060);
    addr0 = memReqAddr_o;
    repeat (5) begin
      step();
      check("bp_valid", 512'(memReqValid_o), 512'(1));
      check("bp_addr", 512'(memReqAddr_o), 512'(addr0));
    end
    check("bp_no_write", 512'(lineWrEnable_o), 512'(0));
    memReqReady_i = 1'b1;
    step();
    check("bp_req_drop", 512'(memReqValid_o), 512'(0));
    check("bp_one_req", 512'(req_cnt - req0), 512'(1));
    finish_refill(8'h05, 0, 51'h2, 8'h03, 5'h01);

    // Gapped beats with a spurious response during REQ
    memReqReady_i = 1'b0;
    present_miss(51'h3, 8'h10, 5'h1F, 64'h6200);
    memRespValid_i = 1'b1; memRespData_i = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    memRespValid_i = 1'b0; memRespData_i = '0;
    memReqReady_i = 1'b1;
    step();
    finish_refill(8'h21, 3, 51'h3, 8'h10, 5'h1F);

    // Miss while busy is ignored, miss in first post-replay idle cycle accepted
    present_miss(51'h4, 8'h05, 5'h02, 64'h80A0);
    step();
    memRespValid_i = 1'b1; memRespData_i = beat(8'h09, 0);
    missValid_i = 1'b1; missTag_i = 51'h7; missIndex_i = 8'h07; missOffset_i = 5'h07;
    step();
    missValid_i = 1'b0; missTag_i = '0; missIndex_i = '0; missOffset_i = '0;
    memRespValid_i = 1'b1; memRespData_i = beat(8'h09, 1);
    step();
    memRespValid_i = 1'b1; memRespData_i = beat(8'h09, 2);
    step();
    memRespValid_i = 1'b1; memRespData_i = beat(8'h09, 3);
    step();
    memRespValid_i = 1'b0; memRespData_i = '0;
    check("busy_wr_data", 512'(lineWrData_o), 512'(exp_line(8'h09)));
    check("busy_wr_tag", 512'(lineWrTag_o), 512'({51'h4, 1'b1}));
    step();
    check("busy_rp_tag", 512'(replayTag_o), 512'(51'h4));
    step();
    check("b2b_idle", 512'(busy_o), 512'(0));
    present_miss(51'h9, 8'h01, 5'h03, 64'h12020);
    step();
    finish_refill(8'h13, 1, 51'h9, 8'h01, 5'h03);

    // Reset mid-fill after two beats
    wr0 = wr_cnt;
    rp0 = rp_cnt;
    present_miss(51'h5, 8'h06, 5'h04, 64'hA0C0);
    step();
    for (int k = 0; k < 2; k++) begin
      memRespValid_i = 1'b1; memRespData_i = beat(8'h31, k);
      step();
    end
    memRespValid_i = 1'b0;
    reset_i = 1'b1;
    #1;
    check("midrst_zero", all_outs, 512'(0));
    step();
    reset_i = 1'b0;
    repeat (4) begin
      memRespValid_i = 1'b1; memRespData_i = 64'hBAD0_BAD0_BAD0_BAD0;
      step();
    end
    memRespValid_i = 1'b0; memRespData_i = '0;
    check("midrst_no_wr", 512'(wr_cnt - wr0), 512'(0));
    check("midrst_no_rp", 512'(rp_cnt - rp0), 512'(0));
    check("midrst_idle", all_outs, 512'(0));
    present_miss(51'h6, 8'h07, 5'h05, 64'hC0E0);
    step();
    finish_refill(8'h41, 0, 51'h6, 8'h07, 5'h05);

    // Index and tag at their maximum values
    present_miss({TAG_SIZE{1'b1}}, 8'hFF, 5'h1F, 64'hFFFF_FFFF_FFFF_FFE0);
    step();
    finish_refill(8'h07, 0, {TAG_SIZE{1'b1}}, 8'hFF, 5'h1F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
